// File: rtl/pe_output_packer_pkg.sv
// Shared precision codes, packing-order constants and config type for the PE output packer.
package pe_output_packer_pkg;

  localparam logic [1:0] PRECISION_8 = 2'd0;
  localparam logic [1:0] PRECISION_4 = 2'd1;
  localparam logic [1:0] PRECISION_2 = 2'd2;

  localparam logic PACK_SPATIAL  = 1'b0;
  localparam logic PACK_TEMPORAL = 1'b1;

  typedef struct packed {
    logic [1:0] precision;
    logic       temporal_mode;
  } packer_cfg_t;

  // The reserved code 3 behaves as full width.
  function automatic logic [1:0] effective_precision(input logic [1:0] p);
    return (p == 2'd3) ? PRECISION_8 : p;
  endfunction

  // Index of the last beat in a group (F-1).
  function automatic logic [1:0] last_beat_index(input logic [1:0] p);
    logic [1:0] idx;
    case (effective_precision(p))
      PRECISION_4: idx = 2'd1;
      PRECISION_2: idx = 2'd3;
      default:     idx = 2'd0;
    endcase
    return idx;
  endfunction

endpackage

// File: rtl/pe_output_packer_lane_reducer.sv
// Reduces one signed lane value to a B-bit field (truncate or clamp), LSB-aligned.
module lane_reducer
  import pe_output_packer_pkg::*;
#(
  parameter int unsigned ACT_DATA_WIDTH = 8,
  parameter bit          SATURATE       = 1'b0
) (
  input  logic [ACT_DATA_WIDTH-1:0] value,
  input  logic [1:0]                precision,
  output logic [ACT_DATA_WIDTH-1:0] field
);

  localparam int unsigned W = ACT_DATA_WIDTH;

  function automatic logic [W-1:0] reduce_to(input logic [W-1:0] v, input int unsigned b);
    logic signed [W:0] sv;
    logic signed [W:0] hi;
    logic signed [W:0] lo;
    logic [W:0]        mask;
    logic [W:0]        r;
    sv   = $signed({v[W-1], v});
    hi   = $signed(((W+1)'(1) << (b - 1)) - (W+1)'(1));
    lo   = ~hi;
    mask = ((W+1)'(1) << b) - (W+1)'(1);
    r    = sv;
    if (SATURATE) begin
      if (sv > hi) begin
        r = hi;
      end else if (sv < lo) begin
        r = lo;
      end
    end
    return W'(r & mask);
  endfunction

  always_comb begin
    field = value;
    unique case (effective_precision(precision))
      PRECISION_4: field = reduce_to(value, W / 2);
      PRECISION_2: field = reduce_to(value, W / 4);
      default:     field = value;
    endcase
  end

endmodule

// File: rtl/pe_output_packer.sv
// Collects 2^p beats of quantised activations and emits one packed word, spatial or temporal order,
// with valid/ready handshake, flush of partial groups and synchronous clear.
module pe_output_packer
  import pe_output_packer_pkg::*;
#(
  parameter int unsigned N_DIM_ARRAY    = 16,
  parameter int unsigned ACT_DATA_WIDTH = 8,
  parameter bit          SATURATE       = 1'b0
) (
  input  logic                                  clk,
  input  logic                                  reset,
  input  logic                                  clear,
  input  logic [1:0]                            precision,
  input  logic                                  temporal_mode,
  input  logic                                  flush,
  input  logic                                  in_valid,
  output logic                                  in_ready,
  input  logic [N_DIM_ARRAY*ACT_DATA_WIDTH-1:0] in_data,
  output logic                                  out_valid,
  input  logic                                  out_ready,
  output logic [N_DIM_ARRAY*ACT_DATA_WIDTH-1:0] out_data,
  output logic                                  out_partial
);

  localparam int unsigned N  = N_DIM_ARRAY;
  localparam int unsigned W  = ACT_DATA_WIDTH;
  localparam int unsigned NW = N * W;
  localparam int unsigned B1 = W / 2;
  localparam int unsigned B2 = W / 4;
  localparam int unsigned G1 = N / 2;
  localparam int unsigned G2 = N / 4;

  typedef enum logic {StEmpty, StFilling} state_e;

  state_e      state_q;
  logic [1:0]  cnt_q;
  packer_cfg_t cfg_q;
  packer_cfg_t cfg_cur;
  logic        flush_pend_q;
  logic [NW-1:0] store_q [3];
  logic [NW-1:0] beat [4];
  logic [W-1:0]  field [4][N];
  logic [NW-1:0] packed_word;
  logic accept;
  logic last;
  logic flush_req;
  logic emit;

  assign in_ready  = !reset && (!out_valid || out_ready);
  assign accept    = in_valid && in_ready;
  // Beat 0 packs with the live config; later beats use the one latched at beat 0.
  assign cfg_cur   = (state_q == StEmpty) ? {effective_precision(precision), temporal_mode} : cfg_q;
  assign last      = accept && (cnt_q == last_beat_index(cfg_cur.precision));
  assign flush_req = flush || flush_pend_q;
  assign emit      = last || (flush_req && in_ready && ((state_q == StFilling) || accept));

  // Missing beats read as zero, which reduces to a zero field.
  always_comb begin
    for (int k = 0; k < 3; k++) begin
      beat[k] = (2'(k) < cnt_q) ? store_q[k] : '0;
    end
    beat[3] = '0;
    for (int k = 0; k < 4; k++) begin
      if (accept && (2'(k) == cnt_q)) beat[k] = in_data;
    end
  end

  for (genvar k = 0; k < 4; k++) begin : g_beat
    for (genvar j = 0; j < N; j++) begin : g_lane
      lane_reducer #(
        .ACT_DATA_WIDTH(W),
        .SATURATE      (SATURATE)
      ) u_lane_reducer (
        .value    (beat[k][j*W +: W]),
        .precision(cfg_cur.precision),
        .field    (field[k][j])
      );
    end
  end

  always_comb begin
    packed_word = '0;
    unique case (cfg_cur.precision)
      PRECISION_4: begin
        if (cfg_cur.temporal_mode == PACK_TEMPORAL) begin
          for (int k = 0; k < 2; k++)
            for (int m = 0; m < N; m++)
              packed_word[m*W + k*B1 +: B1] = field[k][m][B1-1:0];
        end else begin
          for (int k = 0; k < 2; k++)
            for (int s = 0; s < G1; s++)
              for (int t = 0; t < 2; t++)
                packed_word[(k*G1 + s)*W + t*B1 +: B1] = field[k][2*s + t][B1-1:0];
        end
      end
      PRECISION_2: begin
        if (cfg_cur.temporal_mode == PACK_TEMPORAL) begin
          for (int k = 0; k < 4; k++)
            for (int m = 0; m < N; m++)
              packed_word[m*W + k*B2 +: B2] = field[k][m][B2-1:0];
        end else begin
          for (int k = 0; k < 4; k++)
            for (int s = 0; s < G2; s++)
              for (int t = 0; t < 4; t++)
                packed_word[(k*G2 + s)*W + t*B2 +: B2] = field[k][4*s + t][B2-1:0];
        end
      end
      default: begin
        for (int m = 0; m < N; m++) packed_word[m*W +: W] = field[0][m];
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= StEmpty;
      cnt_q        <= 2'd0;
      cfg_q        <= '0;
      flush_pend_q <= 1'b0;
      out_valid    <= 1'b0;
      out_data     <= '0;
      out_partial  <= 1'b0;
      for (int k = 0; k < 3; k++) store_q[k] <= '0;
    end else if (clear) begin
      state_q      <= StEmpty;
      cnt_q        <= 2'd0;
      flush_pend_q <= 1'b0;
      out_valid    <= 1'b0;
      out_data     <= '0;
      out_partial  <= 1'b0;
      for (int k = 0; k < 3; k++) store_q[k] <= '0;
    end else begin
      if (accept && (state_q == StEmpty)) cfg_q <= cfg_cur;
      if (accept && !emit) begin
        for (int k = 0; k < 3; k++) begin
          if (2'(k) == cnt_q) store_q[k] <= in_data;
        end
      end
      if (emit) begin
        state_q      <= StEmpty;
        cnt_q        <= 2'd0;
        flush_pend_q <= 1'b0;
        out_valid    <= 1'b1;
        out_data     <= packed_word;
        out_partial  <= !last;
      end else begin
        if (accept) begin
          state_q <= StFilling;
          cnt_q   <= cnt_q + 2'd1;
        end
        if (flush && !in_ready && (state_q == StFilling)) flush_pend_q <= 1'b1;
        if (out_valid && out_ready) out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_pe_output_packer.sv
// Bench for pe_output_packer: directed vectors, corner sequences and randomized traffic
// against a queue-based reference model; truncating and saturating instances run side by side.
module tb_pe_output_packer;

  localparam int N  = 16;
  localparam int W  = 8;
  localparam int NW = N * W;

  logic          clk = 1'b0;
  logic          reset;
  logic          clear;
  logic [1:0]    precision;
  logic          temporal_mode;
  logic          flush;
  logic          in_valid;
  logic          out_ready;
  logic [NW-1:0] in_data;
  logic          rdy_t, rdy_s, ov_t, ov_s, op_t, op_s;
  logic [NW-1:0] od_t, od_s;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pe_output_packer #(.N_DIM_ARRAY(N), .ACT_DATA_WIDTH(W), .SATURATE(1'b0)) dut_t (
    .clk(clk), .reset(reset), .clear(clear), .precision(precision),
    .temporal_mode(temporal_mode), .flush(flush), .in_valid(in_valid), .in_ready(rdy_t),
    .in_data(in_data), .out_valid(ov_t), .out_ready(out_ready), .out_data(od_t),
    .out_partial(op_t)
  );

  pe_output_packer #(.N_DIM_ARRAY(N), .ACT_DATA_WIDTH(W), .SATURATE(1'b1)) dut_s (
    .clk(clk), .reset(reset), .clear(clear), .precision(precision),
    .temporal_mode(temporal_mode), .flush(flush), .in_valid(in_valid), .in_ready(rdy_s),
    .in_data(in_data), .out_valid(ov_s), .out_ready(out_ready), .out_data(od_s),
    .out_partial(op_s)
  );

  task automatic chk(input string name, input logic [NW-1:0] act, input logic [NW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference model: a group is a queue of accepted beats; packing follows the lane formulas.
  logic [NW-1:0] m_beats[$];
  int            m_p;
  bit            m_t, m_pend, m_ov, m_op;
  logic [NW-1:0] m_od_t, m_od_s;

  function automatic int reduce_val(input int v, input int b, input bit sat);
    int sv;
    int hi;
    if (b == W) return v;
    sv = (v >= 128) ? v - 256 : v;
    hi = (1 << (b - 1)) - 1;
    if (sat) begin
      if (sv > hi) sv = hi;
      else if (sv < -hi - 1) sv = -hi - 1;
    end
    return sv & ((1 << b) - 1);
  endfunction

  function automatic logic [NW-1:0] pack(input int p, input bit t, input bit sat);
    int f = 1 << p;
    int b = W / f;
    int g = N / f;
    int v;
    logic [NW-1:0] w = '0;
    logic [NW-1:0] bk;
    for (int k = 0; k < f; k++) begin
      bk = (k < m_beats.size()) ? m_beats[k] : '0;
      if (t) begin
        for (int m = 0; m < N; m++) begin
          v = reduce_val(int'(bk[m*W +: W]), b, sat);
          w |= NW'(v) << (m*W + b*k);
        end
      end else begin
        for (int s = 0; s < g; s++)
          for (int tt = 0; tt < f; tt++) begin
            v = reduce_val(int'(bk[(f*s + tt)*W +: W]), b, sat);
            w |= NW'(v) << ((k*g + s)*W + b*tt);
          end
      end
    end
    return w;
  endfunction

  task automatic model_reset();
    m_beats.delete();
    m_p = 0; m_t = 0; m_pend = 0; m_ov = 0; m_op = 0;
    m_od_t = '0; m_od_s = '0;
  endtask

  task automatic model_step();
    bit rdy = !m_ov || out_ready;
    bit acc;
    bit emit = 0;
    bit part = 0;
    if (clear) begin
      model_reset();
      return;
    end
    acc = in_valid && rdy;
    if (acc) begin
      if (m_beats.size() == 0) begin
        m_p = (precision == 2'd3) ? 0 : int'(precision);
        m_t = temporal_mode;
      end
      m_beats.push_back(in_data);
    end
    if (acc && m_beats.size() == (1 << m_p)) begin
      emit = 1;
    end else if ((flush || m_pend) && rdy && m_beats.size() > 0) begin
      emit = 1;
      part = 1;
    end else if (flush && !rdy && m_beats.size() > 0) begin
      m_pend = 1;
    end
    if (emit) begin
      m_od_t = pack(m_p, m_t, 1'b0);
      m_od_s = pack(m_p, m_t, 1'b1);
      m_op = part;
      m_ov = 1;
      m_pend = 0;
      m_beats.delete();
    end else if (m_ov && out_ready) begin
      m_ov = 0;
    end
  endtask

  task automatic model_check();
    bit er = !m_ov || out_ready;
    chk("in_ready", NW'(rdy_t), NW'(er));
    chk("in_ready_sat", NW'(rdy_s), NW'(er));
    chk("out_valid", NW'(ov_t), NW'(m_ov));
    chk("out_valid_sat", NW'(ov_s), NW'(m_ov));
    if (m_ov) begin
      chk("out_data", od_t, m_od_t);
      chk("out_data_sat", od_s, m_od_s);
      chk("out_partial", NW'(op_t), NW'(m_op));
      chk("out_partial_sat", NW'(op_s), NW'(m_op));
    end
  endtask

  task automatic drive(input bit v, input logic [NW-1:0] d, input logic [1:0] p, input bit t,
                       input bit fl, input bit orr, input bit cl);
    @(negedge clk);
    in_valid = v; in_data = d; precision = p; temporal_mode = t;
    flush = fl; out_ready = orr; clear = cl;
    #1;
    model_check();
    model_step();
  endtask

  typedef struct {
    logic [1:0]    p;
    bit            t;
    int            nb;
    logic [NW-1:0] beats[4];
    bit            fl;
    logic [NW-1:0] exp_t;
    logic [NW-1:0] exp_s;
    bit            exp_part;
  } vec_t;

  vec_t          vecs[5];
  logic [NW-1:0] snap;
  logic [NW-1:0] w;

  initial begin
    reset = 1'b1; clear = 1'b0; precision = 2'd0; temporal_mode = 1'b0; flush = 1'b0;
    in_valid = 1'b0; out_ready = 1'b0; in_data = '0;
    model_reset();

    for (int i = 0; i < 5; i++) begin
      vecs[i].fl = 0; vecs[i].exp_part = 0;
      for (int b = 0; b < 4; b++) vecs[i].beats[b] = '0;
      vecs[i].exp_t = '0; vecs[i].exp_s = '0;
    end
    // Full width: lane m = m+1 passes straight through.
    vecs[0].p = 2'd0; vecs[0].t = 0; vecs[0].nb = 1;
    for (int m = 0; m < N; m++) vecs[0].beats[0][m*W +: W] = 8'(m + 1);
    vecs[0].exp_t = vecs[0].beats[0]; vecs[0].exp_s = vecs[0].beats[0];
    // Half, temporal: oldest beat in the low nibble.
    vecs[1].p = 2'd1; vecs[1].t = 1; vecs[1].nb = 2;
    vecs[1].beats[0][7:0] = 8'h03; vecs[1].beats[1][7:0] = 8'h05;
    vecs[1].exp_t[7:0] = 8'h53; vecs[1].exp_s[7:0] = 8'h53;
    // Quarter, spatial: lane j = j&3 gives 3,2,1,0 fields; clamping turns 2 and 3 into 1.
    vecs[2].p = 2'd2; vecs[2].t = 0; vecs[2].nb = 4;
    for (int m = 0; m < N; m++) begin
      for (int b = 0; b < 4; b++) vecs[2].beats[b][m*W +: W] = 8'(m & 3);
      vecs[2].exp_t[m*W +: W] = 8'hE4;
      vecs[2].exp_s[m*W +: W] = 8'h54;
    end
    // Half, temporal, extremes: 0x7F/0x80 truncate to F/0, clamp to 7/8.
    vecs[3].p = 2'd1; vecs[3].t = 1; vecs[3].nb = 2;
    vecs[3].beats[0][7:0] = 8'h7F; vecs[3].beats[1][7:0] = 8'h80;
    vecs[3].exp_t[7:0] = 8'h0F; vecs[3].exp_s[7:0] = 8'h87;
    // Quarter, temporal, single beat then flush.
    vecs[4].p = 2'd2; vecs[4].t = 1; vecs[4].nb = 1; vecs[4].fl = 1;
    vecs[4].beats[0][7:0] = 8'h01;
    vecs[4].exp_t[7:0] = 8'h01; vecs[4].exp_s[7:0] = 8'h01; vecs[4].exp_part = 1;

    // Reset state.
    repeat (2) @(negedge clk);
    #1;
    chk("reset_out_valid", NW'(ov_t), '0);
    chk("reset_in_ready", NW'(rdy_t), '0);
    chk("reset_out_data", od_t, '0);
    chk("reset_out_partial", NW'(op_s), '0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("in_ready_after_reset", NW'(rdy_t), NW'(1'b1));

    // Directed vectors.
    for (int i = 0; i < 5; i++) begin
      for (int b = 0; b < vecs[i].nb; b++) begin
        drive(1'b1, vecs[i].beats[b], vecs[i].p, vecs[i].t, 1'b0, 1'b1, 1'b0);
        chk($sformatf("vec%0d_no_early_valid", i), NW'(ov_t), '0);
      end
      if (vecs[i].fl) drive(1'b0, '0, vecs[i].p, vecs[i].t, 1'b1, 1'b1, 1'b0);
      drive(1'b0, '0, vecs[i].p, vecs[i].t, 1'b0, 1'b1, 1'b0);
      chk($sformatf("vec%0d_valid", i), NW'(ov_t), NW'(1'b1));
      chk($sformatf("vec%0d_data", i), od_t, vecs[i].exp_t);
      chk($sformatf("vec%0d_data_sat", i), od_s, vecs[i].exp_s);
      chk($sformatf("vec%0d_partial", i), NW'(op_t), NW'(vecs[i].exp_part));
    end

    // Backpressure: word held for 10 cycles, input stalled, then released.
    w = {$urandom, $urandom, $urandom, $urandom};
    drive(1'b1, w, 2'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    drive(1'b0, '0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("bp_in_ready_low", NW'(rdy_t), '0);
    chk("bp_word", od_t, w);
    snap = od_t;
    for (int c = 0; c < 10; c++) begin
      drive(1'b1, {$urandom, $urandom, $urandom, $urandom}, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0);
      chk("bp_hold_data", od_t, snap);
      chk("bp_hold_valid", NW'(ov_t), NW'(1'b1));
    end
    drive(1'b0, '0, 2'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    chk("bp_release_in_ready", NW'(rdy_t), NW'(1'b1));
    drive(1'b0, '0, 2'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    chk("bp_after_handshake_valid", NW'(ov_t), '0);
    chk("bp_after_handshake_ready", NW'(rdy_t), NW'(1'b1));

    // Reset asserted mid-group: nothing emitted, counter restarts.
    w = '0; w[7:0] = 8'h01;
    drive(1'b1, w, 2'd2, 1'b1, 1'b0, 1'b1, 1'b0);
    @(negedge clk);
    reset = 1'b1; in_valid = 1'b0;
    #1;
    chk("midreset_out_valid", NW'(ov_t), '0);
    chk("midreset_in_ready", NW'(rdy_t), '0);
    model_reset();
    @(negedge clk);
    #1;
    chk("midreset_hold_valid", NW'(ov_s), '0);
    reset = 1'b0;
    for (int b = 0; b < 4; b++) begin
      w = '0; w[7:0] = 8'((b + 1) & 3);
      drive(1'b1, w, 2'd2, 1'b1, 1'b0, 1'b1, 1'b0);
      chk($sformatf("restart_beat%0d_no_valid", b), NW'(ov_t), '0);
    end
    drive(1'b0, '0, 2'd2, 1'b1, 1'b0, 1'b1, 1'b0);
    w = '0; w[7:0] = 8'h39;
    chk("restart_data", od_t, w);
    w = '0; w[7:0] = 8'h15;
    chk("restart_data_sat", od_s, w);
    chk("restart_partial", NW'(op_t), '0);

    // Randomized traffic against the model.
    for (int c = 0; c < 3000; c++) begin
      w = {$urandom, $urandom, $urandom, $urandom};
      if ($urandom_range(0, 3) == 0) w[7:0] = ($urandom_range(0, 1) == 0) ? 8'h7F : 8'h80;
      drive($urandom_range(0, 3) != 0, w, 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
            $urandom_range(0, 7) == 0, $urandom_range(0, 3) != 0, $urandom_range(0, 63) == 0);
    end
    drive(1'b0, '0, 2'd0, 1'b0, 1'b0, 1'b1, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pe_output_packer.md
Name: pe_output_packer

Overview:
- Parametrised output-precision packer between the PE array outputs and the activation write-back path.
- Collects 2^p beats of N quantised activations, where p is the precision code, and emits one N-lane word of packed 8/4/2-bit values.
- Supports two packing orders: spatial (FC/EWS) and temporal (CNN).
- New over the previous output stage: valid/ready handshake with backpressure, optional saturation, flush of partial groups with zero fill, and any N and width.

Parameters:
N_DIM_ARRAY, 16, number of lanes; must be divisible by 4.
ACT_DATA_WIDTH, 8, lane width in bits; must be divisible by 4.
SATURATE, 0, 1 = clamp to signed B-bit range; 0 = truncate to the low B bits.

Ports:
clk  in  1  clock.
reset  in  1  asynchronous, active-high reset.
clear  in  1  synchronous drop of all buffered state.
precision  in  2  0 = full width, 1 = half, 2 = quarter, 3 = reserved (treated as 0).
temporal_mode  in  1  1 = CNN temporal packing, 0 = FC/EWS spatial packing.
flush  in  1  pulse; emit the pending partial group.
in_valid  in  1  input beat valid.
in_ready  out  1  input beat accepted when in_valid && in_ready.
in_data  in  N_DIM_ARRAY x ACT_DATA_WIDTH  signed activations, one per lane.
out_valid  out  1  packed word valid.
out_ready  in  1  downstream accepts the word.
out_data  out  N_DIM_ARRAY x ACT_DATA_WIDTH  packed word.
out_partial  out  1  word was produced by flush with missing beats.

Behaviour:
- Definitions: F = 2^p beats per group, B = ACT_DATA_WIDTH/F bits per value, G = N_DIM_ARRAY/F.
- Beat index k counts 0..F-1 in arrival order.
- Reset: all outputs 0 (out_valid=0, in_ready=0 during reset), beat counter 0, beat store 0.
- First cycle after reset release: in_ready=1.
- Value reduction:
  - SATURATE=0: v[B-1:0].
  - SATURATE=1: clamp v to [-2^(B-1), 2^(B-1)-1], then take B bits.
  - Full width (B=ACT_DATA_WIDTH) passes values unchanged.
- Temporal packing: out[m][B*k +: B] = reduce(beat_k[m]). The oldest beat sits in the LSBs.
- Spatial packing: for m = k*G + s, out[m][B*t +: B] = reduce(beat_k[F*s + t]) for t = 0..F-1. The lower lane sits in the LSBs.
- Config sampling:
  - precision and temporal_mode are latched when beat 0 of a group is accepted.
  - Changes mid-group are ignored until the next group.
- Beat store:
  - Holds F-1 beats; the F-th beat is packed directly from in_data.
  - F=1: every accepted beat loads the output register.
- Output register and latency:
  - Packed word loads on the clock edge that accepts the last beat.
  - out_valid rises the next cycle; latency from last beat to out_valid is 1 cycle.
- Handshake:
  - in_ready = !out_valid || out_ready.
  - Full throughput: one group per F cycles with out_ready held high.
  - out_data and out_partial are held stable while out_valid && !out_ready.
  - Output register clears out_valid on out_valid && out_ready unless reloaded on the same edge.
- Counter FSM:
  - EMPTY: cnt=0. An accepted beat goes to FILLING, or to EMPTY with an emit if F=1.
  - FILLING: 0 < cnt < F. The accepted last beat emits and returns to EMPTY.
  - The counter wraps at F.
- Flush:
  - In FILLING with in_ready=1: emit the partial word on the next edge; missing beats are zero, out_partial=1, go to EMPTY.
  - In FILLING with in_ready=0: the flush is held pending until in_ready=1.
  - In EMPTY: no effect.
- Flush in the same cycle as an accepted beat:
  - The beat is stored first, then flush applies.
  - If that beat completes the group, the word is a normal emit with out_partial=0.
- Clear:
  - Counter goes to 0, out_valid=0, pending flush is dropped, beat store is zeroed.
  - Clear has priority over in/flush in the same cycle.
- Reset asserted mid-group or with out_valid=1: immediate return to the reset state; no word is emitted.

Decomposition:
- Shared parameters package:
  - PRECISION_8/4/2 codes (0/1/2).
  - Packing-mode constants PACK_SPATIAL/PACK_TEMPORAL.
  - pe_output_packer config struct {precision, temporal_mode}.
- Sub-module lane_reducer:
  - Parameters ACT_DATA_WIDTH and SATURATE.
  - Function: value plus B-select → reduced field.
  - Instantiated per lane per beat.

Test Plan:
1. N=16, W=8, p=0: lanes m=m+1 -> next cycle out_valid=1, out_data lane m = m+1, out_partial=0.
2. p=1, temporal: lane0 beats 0x03 then 0x05 -> lane0 = 0x53, out_valid one cycle after the second beat.
3. p=2, spatial: every beat lane j = j&3 -> lanes 0..15 all 0xE4, emitted after the 4th beat.
4. p=1, temporal: lane0 beats 0x7F then 0x80 -> SATURATE=1 gives 0x87; SATURATE=0 gives 0x0F.
5. Backpressure: out_ready=0 after an emit -> in_ready=0; out_data stable 10 cycles; out_ready=1 -> handshake, in_ready=1 the next cycle.
6. p=2, temporal: one beat lane0=0x01, then flush -> lane0 = 0x01, out_partial=1. Repeat with reset asserted mid-group -> out_valid stays 0 and the counter restarts.
